// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package wb_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NREG);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear to the same register in one cycle leaves it set;
// register 0 never reads busy.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int unsigned NREG = wb_pkg::NREG,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_set_valid,
    input  logic [AW-1:0]   i_set_addr,
    input  logic            i_clr_valid,
    input  logic [AW-1:0]   i_clr_addr,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    // Apply clear first, then set, so a same-cycle set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_valid) begin
            w_busy_next[i_clr_addr] = 1'b0;
        end
        if (i_set_valid) begin
            w_busy_next[i_set_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and LSU results onto the single register-file write port
// and tracks pending writes for decode hazard stalls.
// Build option: WB_ROUND_ROBIN_EN selects round-robin conflict resolution;
// without it the LSU always wins a conflict.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = wb_pkg::XLEN,
    parameter int unsigned NREG = wb_pkg::NREG,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [AW-1:0]   i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [AW-1:0]   i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    output logic [NREG-1:0] o_busy,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_wr_addr,
    output logic [XLEN-1:0] o_rf_wr_data
);

    logic            w_alu_wins;
    logic            w_grant_alu;
    logic            w_grant_lsu;
    logic            w_accept;
    wb_req_t         w_req;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_wr_addr;
    logic [XLEN-1:0] r_rf_wr_data;

`ifdef WB_ROUND_ROBIN_EN
    wb_src_e r_last_grant;

    // Remember the winner of each conflict; reset favours the ALU next.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= SRC_LSU;
        end else if (i_alu_valid && i_lsu_valid) begin
            r_last_grant <= w_grant_alu ? SRC_ALU : SRC_LSU;
        end
    end

    assign w_alu_wins = (r_last_grant == SRC_LSU);
`else
    assign w_alu_wins = 1'b0;
`endif

    // Grant selection and request mux; nothing is accepted during reset.
    always_comb begin
        w_grant_alu = !i_rst && i_alu_valid && (!i_lsu_valid || w_alu_wins);
        w_grant_lsu = !i_rst && i_lsu_valid && !w_grant_alu;
        w_accept    = w_grant_alu || w_grant_lsu;
        w_req.rd    = i_alu_rd;
        w_req.data  = i_alu_data;
        if (w_grant_lsu) begin
            w_req.rd   = i_lsu_rd;
            w_req.data = i_lsu_data;
        end
    end

    assign o_alu_ready = w_grant_alu;
    assign o_lsu_ready = w_grant_lsu;

    // Register the accepted result; writes to register 0 are dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rf_we      <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wr_data <= '0;
        end else begin
            r_rf_we <= w_accept && (w_req.rd != '0);
            if (w_accept) begin
                r_rf_wr_addr <= w_req.rd;
                r_rf_wr_data <= w_req.data;
            end
        end
    end

    assign o_rf_we      = r_rf_we;
    assign o_rf_wr_addr = r_rf_wr_addr;
    assign o_rf_wr_data = r_rf_wr_data;

    wb_scoreboard #(.NREG(NREG)) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_set_valid (i_issue_valid && (i_issue_rd != '0)),
        .i_set_addr  (i_issue_rd),
        .i_clr_valid (r_rf_we),
        .i_clr_addr  (r_rf_wr_addr),
        .o_busy      (o_busy)
    );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
// Expectations follow WB_ROUND_ROBIN_EN when it is defined for the build.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;

    int checks = 0;
    int errors = 0;

`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    writeback_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_valid   (alu_valid),
        .o_alu_ready   (alu_ready),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .i_lsu_valid   (lsu_valid),
        .o_lsu_ready   (lsu_ready),
        .i_lsu_rd      (lsu_rd),
        .i_lsu_data    (lsu_data),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .o_busy        (busy),
        .o_rf_we       (rf_we),
        .o_rf_wr_addr  (rf_wr_addr),
        .o_rf_wr_data  (rf_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd1; lsu_rd = 5'd2; alu_data = 64'h11; lsu_data = 64'h22;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        tick();
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: alu=%b lsu=%b want 0 0", alu_ready, lsu_ready);
        end
        checks++;
        if (rf_we !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 64'd0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h busy=%h want all 0",
                     rf_we, rf_wr_addr, rf_wr_data, busy);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_only_ready: alu=%b lsu=%b want 1 0", alu_ready, lsu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 64'h1234) begin
            errors++;
            $display("FAIL alu_only_write: we=%b addr=%0d data=%h want 1 5 1234",
                     rf_we, rf_wr_addr, rf_wr_data);
        end
        #1;
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_idle_ready: alu_ready=%b want 0", alu_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_we_pulse: rf_we=%b want 0", rf_we);
        end
    endtask

    task automatic test_conflict();
        logic       exp_alu;
        logic [4:0] exp_addr;
        logic [63:0] exp_data;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hAAAA_0003;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'hBBBB_0007;
        for (int i = 0; i < 4; i++) begin
            exp_alu  = RR && (i % 2 == 0);
            exp_addr = exp_alu ? 5'd3 : 5'd7;
            exp_data = exp_alu ? 64'hAAAA_0003 : 64'hBBBB_0007;
            #1;
            checks++;
            if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
                errors++;
                $display("FAIL conflict_ready[%0d]: alu=%b lsu=%b want %b %b",
                         i, alu_ready, lsu_ready, exp_alu, !exp_alu);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_wr_addr !== exp_addr || rf_wr_data !== exp_data) begin
                errors++;
                $display("FAIL conflict_write[%0d]: we=%b addr=%0d data=%h want 1 %0d %h",
                         i, rf_we, rf_wr_addr, rf_wr_data, exp_addr, exp_data);
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_set: busy=%h want 00000200", busy);
        end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_wr_addr !== 5'd9 || busy !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_write1: we=%b addr=%0d busy=%h want 1 9 00000200",
                     rf_we, rf_wr_addr, busy);
        end
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0200 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL sb_set_wins: busy=%h we=%b want 00000200 0", busy, rf_we);
        end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h98;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || busy !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_write2: we=%b busy=%h want 1 00000200", rf_we, busy);
        end
        tick();
        checks++;
        if (busy !== 32'd0) begin
            errors++;
            $display("FAIL sb_clear: busy=%h want 00000000", busy);
        end
    endtask

    task automatic test_rd0();
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hDEAD;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_ready: lsu=%b alu=%b want 1 0", lsu_ready, alu_ready);
        end
        tick();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || busy !== 32'h0000_0010) begin
            errors++;
            $display("FAIL rd0_nowrite: we=%b busy=%h want 0 00000010", rf_we, busy);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || busy !== 32'h0000_0010) begin
            errors++;
            $display("FAIL rd0_after: we=%b busy=%h want 0 00000010", rf_we, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp_addr;
        // Conflict that (round-robin) the ALU wins, so last_grant becomes ALU.
        issue_valid = 1'b1; issue_rd = 5'd12;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
        tick();
        issue_valid = 1'b0;
        exp_addr = RR ? 5'd6 : 5'd7;
        checks++;
        if (rf_we !== 1'b1 || rf_wr_addr !== exp_addr) begin
            errors++;
            $display("FAIL mid_prewrite: we=%b addr=%0d want 1 %0d", rf_we, rf_wr_addr, exp_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || busy !== 32'd0 || alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: we=%b busy=%h alu=%b lsu=%b want 0 0 0 0",
                     rf_we, busy, alu_ready, lsu_ready);
        end
        tick();
        rst = 1'b0;
        alu_rd = 5'd3; alu_data = 64'h33;
        lsu_rd = 5'd7; lsu_data = 64'h77;
        #1;
        checks++;
        if (alu_ready !== RR || lsu_ready !== !RR) begin
            errors++;
            $display("FAIL post_reset_grant: alu=%b lsu=%b want %b %b",
                     alu_ready, lsu_ready, RR, !RR);
        end
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        exp_addr = RR ? 5'd3 : 5'd7;
        checks++;
        if (rf_we !== 1'b1 || rf_wr_addr !== exp_addr) begin
            errors++;
            $display("FAIL post_reset_write: we=%b addr=%0d want 1 %0d", rf_we, rf_wr_addr, exp_addr);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        test_reset();
        test_alu_only();
        test_conflict();
        test_scoreboard();
        test_rd0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Collects completed results from the ALU and the load/store unit, arbitrates them onto the register file's single write port (`rf_we` / `rf_wr_addr` / `rf_wr_data`), and maintains a per-register pending-write scoreboard that decode uses to stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file, acting as the sole driver of the register-file write port.

## Interface
Parameters:
- `XLEN`, 64, data width of results and the register-file write port.
- `NREG`, 32, number of architectural registers. Register-address width is `$clog2(NREG)`, which is 5 bits.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset. Asynchronous, active-high.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `lsu_valid`  in  1  LSU load result available.
- `lsu_ready`  out  1  LSU result accepted this cycle.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  XLEN  LSU load data.
- `issue_valid`  in  1  Decode issues an instruction that writes `issue_rd`.
- `issue_rd`  in  5  Destination register of the issued instruction.
- `busy`  out  NREG  Scoreboard. Bit i set means a write to register i is pending.
- `rf_we`  out  1  Register-file write enable.
- `rf_wr_addr`  out  5  Register-file write address.
- `rf_wr_data`  out  XLEN  Register-file write data.

## Operation
- **Handshake:** a transfer occurs in a cycle where `x_valid && x_ready`. The source holds `rd`/`data` stable while `valid && !ready`.
- **Ready rules:**
  - `x_ready` is combinational. It is high only for the granted source and only while that source's `valid` is high.
  - At most one source is accepted per cycle.
- **Arbitration:**
  - If only one source is valid, that source is granted.
  - If both are valid, the grant is round-robin: the source not granted in the most recent conflict wins.
  - A 1-bit `last_grant` register records the previous conflict winner. It updates only on conflict cycles.
- **Output register:**
  - An accepted result loads `rf_wr_addr` and `rf_wr_data` on the next edge.
  - `rf_we` is asserted for one cycle, but only if `rd != 0`.
  - A result with `rd == 0` is still accepted (ready goes high), but no write is produced.
- **Scoreboard:**
  - `issue_valid` with `issue_rd != 0` sets `busy[issue_rd]`.
  - A cycle with `rf_we` clears `busy[rf_wr_addr]`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - `busy[0]` is always 0.
  - Issuing to a register that is already busy leaves it set. Preventing this is decode's responsibility, and it is not an error.
- **Reset:**
  - `rf_we`=0, `rf_wr_addr`=0, `rf_wr_data`=0, `busy`=0.
  - `last_grant` resets to LSU, so the ALU wins the first conflict.
  - `alu_ready` and `lsu_ready` are 0 while `rst` is high.
  - A reset asserted mid-operation discards any registered write: `rf_we` drops immediately (asynchronously).

## Timing
- Latency from handshake to `rf_we` is 1 cycle. Throughput is one write per cycle, with no back-pressure from the register file.
- `busy` is registered:
  - A set becomes visible the cycle after `issue_valid`.
  - A clear becomes visible the cycle after `rf_we`.
- Sustained conflict: grants alternate ALU, LSU, ALU, and so on. Each source is guaranteed a grant within 2 cycles.

## Configuration
- `WB_ROUND_ROBIN_EN`:
  - Defined: arbitration is round-robin as described above.
  - Undefined: fixed priority, LSU always wins a conflict, and `last_grant` is not instantiated. An ALU result can then starve under continuous LSU traffic; this is acceptable for single-issue use.

## Structure
- Package `wb_pkg` holds:
  - Constants `XLEN`, `NREG`, `REG_ADDR_W`.
  - `typedef struct packed {logic [REG_ADDR_W-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
  - `typedef enum logic {SRC_ALU, SRC_LSU} wb_src_e`.
- One sub-module, `wb_scoreboard`, contains the busy vector and its set/clear logic: inputs are set valid/addr and clear valid/addr, output is `busy`.

## Test plan
- ALU only: `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 → `alu_ready`=1 the same cycle; next cycle `rf_we`=1, `rf_wr_addr`=5, `rf_wr_data`=0x1234.
- Conflict, round-robin build: both sources valid for 4 cycles with `rd` 3 (ALU) and 7 (LSU) → writes go to 3, 7, 3, 7; exactly one ready per cycle.
- Conflict, macro undefined: same stimulus → writes go to 7, 7, 7, 7 and `alu_ready` stays 0.
- rd=0: `lsu_valid`, `lsu_rd`=0 → `lsu_ready`=1; `rf_we` stays 0; `busy` unchanged.
- Scoreboard: issue rd=9 → `busy[9]`=1 the next cycle. A write to 9 plus a same-cycle issue to 9 → `busy[9]` stays 1. A lone write to 9 → `busy[9]`=0 the following cycle.
- Reset mid-write: assert `rst` in the cycle `rf_we`=1 → `rf_we`, `busy`, and the ready outputs go to 0 immediately. After release, the first conflict grants the ALU.
